// File: rtl/raccoon_pkg.sv
// Shared Raccoon constants, sampler FSM state type and a byte-reversal helper.
package raccoon_pkg;

  localparam int unsigned RACCOON_COEF_W = 49;
  localparam logic [RACCOON_COEF_W-1:0] RACCOON_Q = 49'h1f41002f80001;
  localparam int unsigned RACCOON_N = 256;

  // Widest word the byteswap helper handles; callers zero-extend into it.
  localparam int unsigned BSWAP_MAX_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reverses the low nbytes bytes of w: byte nbytes-1 becomes byte 0.
  function automatic logic [8*BSWAP_MAX_BYTES-1:0] byteswap(
    input logic [8*BSWAP_MAX_BYTES-1:0] w,
    input int unsigned                  nbytes
  );
    logic [8*BSWAP_MAX_BYTES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BSWAP_MAX_BYTES; i++) begin
      if (i < nbytes) r[8*i +: 8] = w[8*(nbytes-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; simultaneous push and pop are both honoured.
module sync_fifo #(
  parameter  int unsigned WIDTH = 50,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_a_rej.sv
// Raccoon A-matrix rejection sampler: byteswapped XOF words kept iff < Q, buffered to the output.
// Optional rej_cnt statistics port is enabled by defining SAMPLE_A_REJ_STATS_EN.
module sample_a_rej
  import raccoon_pkg::*;
#(
  parameter int unsigned       COEF_W     = RACCOON_COEF_W,
  parameter int unsigned       IN_BYTES   = 7,
  parameter logic [COEF_W-1:0] Q          = RACCOON_Q,
  parameter int unsigned       NUM_COEF   = RACCOON_N,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [8*IN_BYTES-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [COEF_W-1:0]     dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_last,
  output logic                  busy,
  output logic                  done
`ifdef SAMPLE_A_REJ_STATS_EN
  ,
  output logic [15:0]           rej_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_COEF+1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] N_FULL  = CNT_W'(NUM_COEF);
  localparam logic [CNT_W-1:0] N_LAST  = CNT_W'(NUM_COEF-1);
  localparam logic [FCW:0]     DEPTH_C = (FCW+1)'(FIFO_DEPTH);

  state_t            state;
  state_t            state_nx;
  logic              stg_valid;
  logic [COEF_W-1:0] stg_cand;
  logic [COEF_W-1:0] cand;
  logic [CNT_W-1:0]  acc_cnt;
  logic              din_hs;
  logic              stg_acc;
  logic              push;
  logic              last_push;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [COEF_W:0]   fifo_head;
  logic [FCW:0]      occupancy;

  assign cand      = COEF_W'(byteswap((8*BSWAP_MAX_BYTES)'(din), IN_BYTES));
  assign din_hs    = din_valid && din_ready;
  assign stg_acc   = stg_valid && (stg_cand < Q);
  assign push      = stg_acc && (acc_cnt < N_FULL);
  assign last_push = push && (acc_cnt == N_LAST);
  // Counting the stage register as occupied guarantees a slot for its push.
  assign occupancy = {1'b0, fifo_count} + {{FCW{1'b0}}, stg_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_push) state_nx = DRAIN;
      DRAIN:   if (fifo_empty && !stg_valid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state == RUN) && (occupancy < DEPTH_C);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_cand  <= '0;
      acc_cnt   <= '0;
    end else begin
      stg_valid <= din_hs;
      if (din_hs) stg_cand <= cand;
      if (state == IDLE && start) acc_cnt <= '0;
      else if (push)              acc_cnt <= acc_cnt + 1'b1;
    end
  end

`ifdef SAMPLE_A_REJ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt <= '0;
    end else if (state == IDLE && start) begin
      rej_cnt <= '0;
    end else if (state == RUN && stg_valid && !(stg_cand < Q) && rej_cnt != 16'hFFFF) begin
      rej_cnt <= rej_cnt + 1'b1;
    end
  end
`endif

  sync_fifo #(
    .WIDTH (COEF_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !fifo_full),
    .wdata ({last_push, stg_cand}),
    .pop   (dout_ready),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? '0 : fifo_head[COEF_W-1:0];
  assign dout_last  = !fifo_empty && fifo_head[COEF_W];

endmodule
